mdr_bcd_display: RTL and testbench
==================================

MDR_BCD_DISPLAY -- requirements
Module: mdr_bcd_display

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 16, the width of the result/remainder input words.
REQ-002 SHALL have parameter DIGITS, default 5, the number of BCD digits; legal only when 10^DIGITS > 2^WORD_LENGTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge triggered.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port ready, input, 1 bit: the completion flag from the multiply/divide/root stage.
REQ-006 SHALL have port result, input, WORD_LENGTH bits: the unsigned magnitude of the result.
REQ-007 SHALL have port remainder, input, WORD_LENGTH bits: the unsigned remainder.
REQ-008 SHALL have port sign, input, 1 bit: the result sign, 1 = negative.
REQ-009 SHALL have port bcd_result, output, 4*DIGITS bits: the BCD result, digit 0 in bits [3:0].
REQ-010 SHALL have port bcd_remainder, output, 4*DIGITS bits: the BCD remainder.
REQ-011 SHALL have port seg_result, output, 7*DIGITS bits: active-low segments, per digit {g,f,e,d,c,b,a}, digit 0 in bits [6:0].
REQ-012 SHALL have port sign_out, output, 1 bit: the registered sign of the displayed value.
REQ-013 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-014 SHALL have port done, output, 1 bit: a one-cycle pulse when the outputs update.

Function
REQ-015 SHALL detect a rising edge of ready using a register ready_q, so that edge = ready & ~ready_q.
REQ-016 SHALL implement an FSM with states IDLE, CONV_RES, CONV_REM and DONE.
REQ-017 SHALL, in IDLE on an edge at posedge T0, capture result, remainder and sign, clear the BCD shift register and counter, and enter CONV_RES.
REQ-018 SHALL, in CONV_RES, perform one double-dabble step per cycle (add 3 to every digit >= 5, then shift in the MSB) for exactly WORD_LENGTH cycles.
REQ-019 SHALL route CONV_RES to DONE when the macro is absent, and to CONV_REM when it is present.
REQ-020 SHALL, in CONV_REM, convert the remainder in the same way in WORD_LENGTH cycles and then enter DONE.
REQ-021 SHALL, in DONE, load bcd_result, bcd_remainder, seg_result and sign_out, pulse done for one cycle and return to IDLE.
REQ-022 SHALL pulse done at T0+WORD_LENGTH+1 without the macro and at T0+2*WORD_LENGTH+1 with it.
REQ-023 SHALL hold busy high from T0+1 through the done cycle inclusive.
REQ-024 SHALL hold all outputs at their previous values during a conversion (double-buffered).
REQ-025 SHALL ignore ready edges while not in IDLE; no request is queued.
REQ-026 SHALL blank leading-zero digits (segments 7'h7F); digit 0 is never blanked, so a value of 0 displays "0".
REQ-027 SHALL treat a BCD digit > 9 as unreachable for legal parameters; the segment decoder outputs blank for such a digit.

Reset
REQ-028 SHALL, on reset low at any time including mid-conversion, abort the conversion, enter IDLE, and clear ready_q, bcd_result, bcd_remainder, sign_out, busy and done to 0.
REQ-029 SHALL drive seg_result at reset to digit 0 = 7'h40 and all other digits = 7'h7F.
REQ-030 SHALL treat ready already high on the first clock after reset release as an edge and start a conversion.

Configuration
REQ-031 SHALL, with macro MDR_BCD_REMAINDER_EN defined, include the CONV_REM state and drive bcd_remainder with the converted remainder.
REQ-032 SHALL, without MDR_BCD_REMAINDER_EN, omit the CONV_REM state, tie bcd_remainder to 0, and use latency WORD_LENGTH+1.

Structure
REQ-033 SHALL place in package mdr_bcd_pkg: the FSM state enum typedef, the constants SEG_BLANK = 7'h7F and SEG_ZERO = 7'h40, and the 10-entry digit-to-segment table.
REQ-034 SHALL use one sub-module, bcd_to_seg (one BCD digit plus a blank flag in, 7 active-low segments out), instantiated DIGITS times.

Verification
REQ-035 SHALL cover: result=12345, sign=0, ready 0->1 at T0 -> done at T0+17 (macro off), bcd_result=20'h12345, busy high T0+1..T0+17.
REQ-036 SHALL cover: result=0 -> bcd_result=0, digit 0 = 7'h40, digits 1-4 = 7'h7F.
REQ-037 SHALL cover: result=65535 -> bcd_result=20'h65535, with no digit > 9 at any step.
REQ-038 SHALL cover: macro on, result=7, remainder=3 -> done at T0+33, bcd_result=20'h00007, bcd_remainder=20'h00003.
REQ-039 SHALL cover: second ready edge at T0+5 -> ignored, done pulses once; reset low at T0+8 -> busy=0, outputs at reset values, no done.
REQ-040 SHALL cover: result=42, sign=1 -> sign_out=1 at done, unchanged until the next done.

Source files
------------

// File: rtl/mdr_bcd_pkg.sv
// Shared types and constants for the BCD display converter.
// MDR_BCD_REMAINDER_EN adds the remainder conversion state.
package mdr_bcd_pkg;

`ifdef MDR_BCD_REMAINDER_EN
  typedef enum logic [1:0] {IDLE, CONV_RES, CONV_REM, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, CONV_RES, DONE} state_t;
`endif

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  // Active-low {g,f,e,d,c,b,a}, index = decimal digit
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/bcd_to_seg.sv
// One BCD digit to active-low seven-segment pattern, with blanking.
module bcd_to_seg
  import mdr_bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && digit <= 4'd9) seg = SEG_TABLE[digit];
  end

endmodule

// File: rtl/mdr_bcd_display.sv
// Double-dabble BCD converter and seven-segment driver for the mul/div/root result.
// Define MDR_BCD_REMAINDER_EN to also convert and present the remainder.
module mdr_bcd_display
  import mdr_bcd_pkg::*;
#(
  parameter int WORD_LENGTH = 16,
  parameter int DIGITS      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ready,
  input  logic [WORD_LENGTH-1:0]   result,
  input  logic [WORD_LENGTH-1:0]   remainder,
  input  logic                     sign,
  output logic [4*DIGITS-1:0]      bcd_result,
  output logic [4*DIGITS-1:0]      bcd_remainder,
  output logic [7*DIGITS-1:0]      seg_result,
  output logic                     sign_out,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WORD_LENGTH - 1);
  localparam logic [7*DIGITS-1:0] SEG_RESET = {{(DIGITS-1){SEG_BLANK}}, SEG_ZERO};

  state_t                  state;
  logic                    ready_q;
  logic                    edge_det;
  logic [CW-1:0]           cnt;
  logic                    last;
  logic [WORD_LENGTH-1:0]  bin;
  logic [4*DIGITS-1:0]     bcd;
  logic [4*DIGITS-1:0]     bcd_step;
  logic [4*DIGITS-1:0]     load_res;
  logic                    sign_buf;
  logic [DIGITS-1:0]       blank;
  logic [7*DIGITS-1:0]     seg_next;

  function automatic logic [4*DIGITS-1:0] dabble_adjust(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    return r;
  endfunction

  assign edge_det = ready & ~ready_q;
  assign last     = (cnt == LAST_STEP);
  assign bcd_step = {dabble_adjust(bcd)[4*DIGITS-2:0], bin[WORD_LENGTH-1]};

`ifdef MDR_BCD_REMAINDER_EN
  logic [WORD_LENGTH-1:0] rem_buf;
  logic [4*DIGITS-1:0]    res_buf;
  assign load_res = res_buf;
`else
  logic unused_rem;
  assign unused_rem    = ^remainder;
  assign load_res      = bcd_step;
  assign bcd_remainder = '0;
`endif

  // Segment patterns for the value about to be displayed
  for (genvar i = 0; i < DIGITS; i++) begin : g_seg
    if (i == 0) begin : g_lsd
      assign blank[i] = 1'b0;
    end else begin : g_msd
      assign blank[i] = (load_res[4*DIGITS-1:4*i] == '0);
    end
    bcd_to_seg u_seg (
      .digit (load_res[4*i +: 4]),
      .blank (blank[i]),
      .seg   (seg_next[7*i +: 7])
    );
  end

  // Shift datapath: no reset needed, always loaded before use
  always_ff @(posedge clk) begin
    if (state == IDLE && edge_det) begin
      bin      <= result;
      sign_buf <= sign;
      bcd      <= '0;
`ifdef MDR_BCD_REMAINDER_EN
      rem_buf  <= remainder;
`endif
    end else if (state != IDLE && state != DONE) begin
      bcd <= bcd_step;
      bin <= {bin[WORD_LENGTH-2:0], 1'b0};
`ifdef MDR_BCD_REMAINDER_EN
      if (state == CONV_RES && last) begin
        res_buf <= bcd_step;
        bcd     <= '0;
        bin     <= rem_buf;
      end
`endif
    end
  end

  // Control and double-buffered outputs, loaded on entry to DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ready_q    <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd_result <= '0;
      seg_result <= SEG_RESET;
      sign_out   <= 1'b0;
`ifdef MDR_BCD_REMAINDER_EN
      bcd_remainder <= '0;
`endif
    end else begin
      ready_q <= ready;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (edge_det) begin
            state <= CONV_RES;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CONV_RES: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            cnt <= '0;
`ifdef MDR_BCD_REMAINDER_EN
            state <= CONV_REM;
`else
            state      <= DONE;
            done       <= 1'b1;
            bcd_result <= load_res;
            seg_result <= seg_next;
            sign_out   <= sign_buf;
`endif
          end
        end
`ifdef MDR_BCD_REMAINDER_EN
        CONV_REM: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            cnt           <= '0;
            state         <= DONE;
            done          <= 1'b1;
            bcd_result    <= load_res;
            bcd_remainder <= bcd_step;
            seg_result    <= seg_next;
            sign_out      <= sign_buf;
          end
        end
`endif
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdr_bcd_display.sv
// Self-checking bench for mdr_bcd_display: vector table, random values, reset/retrigger corners.
module tb_mdr_bcd_display;

  localparam int W = 16;
  localparam int D = 5;
`ifdef MDR_BCD_REMAINDER_EN
  localparam int LAT = 2*W + 1;
`else
  localparam int LAT = W + 1;
`endif
  localparam logic [7*D-1:0] SEG_RST = {{(D-1){7'h7F}}, 7'h40};

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           ready = 1'b0;
  logic [W-1:0]   result = '0;
  logic [W-1:0]   remainder = '0;
  logic           sign = 1'b0;
  logic [4*D-1:0] bcd_result;
  logic [4*D-1:0] bcd_remainder;
  logic [7*D-1:0] seg_result;
  logic           sign_out;
  logic           busy;
  logic           done;

  int total = 0;
  int bad   = 0;

  logic [4*D-1:0] prev_bcd = '0;
  logic [4*D-1:0] prev_rem = '0;
  logic [7*D-1:0] prev_seg = SEG_RST;
  logic           prev_sign = 1'b0;

  mdr_bcd_display #(.WORD_LENGTH(W), .DIGITS(D)) dut (
    .clk           (clk),
    .reset         (reset),
    .ready         (ready),
    .result        (result),
    .remainder     (remainder),
    .sign          (sign),
    .bcd_result    (bcd_result),
    .bcd_remainder (bcd_remainder),
    .seg_result    (seg_result),
    .sign_out      (sign_out),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned    res;
    int unsigned    rem;
    bit             sg;
    logic [4*D-1:0] eb;
    logic [4*D-1:0] er;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dec7(input int unsigned d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [4*D-1:0] m_bcd(input int unsigned v);
    logic [4*D-1:0] r;
    int unsigned x;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [7*D-1:0] m_seg(input int unsigned v);
    logic [7*D-1:0] s;
    int unsigned p;
    p = 1;
    for (int i = 0; i < D; i++) begin
      s[7*i +: 7] = (i > 0 && v < p) ? 7'h7F : dec7((v / p) % 10);
      p = p * 10;
    end
    return s;
  endfunction

  task automatic start(input int unsigned r, input int unsigned rm, input bit s);
    @(negedge clk);
    result    = r[W-1:0];
    remainder = rm[W-1:0];
    sign      = s;
    ready     = 1'b1;
    @(posedge clk);
  endtask

  // Called right after the capture edge; poke>0 raises ready again at that cycle
  task automatic watch(input int unsigned r, input int unsigned rm, input bit s, input int poke);
    logic [4*D-1:0] eb, er;
    logic [7*D-1:0] es;
    eb = m_bcd(r);
`ifdef MDR_BCD_REMAINDER_EN
    er = m_bcd(rm);
`else
    er = '0;
`endif
    es = m_seg(r);
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk);
      if (k == 1) ready = 1'b0;
      if (poke > 0 && k == poke) ready = 1'b1;
      check("busy", busy, (k <= LAT));
      check("done", done, (k == LAT));
      if (k < LAT) begin
        check("hold_bcd", bcd_result, prev_bcd);
        check("hold_seg", seg_result, prev_seg);
        check("hold_sign", sign_out, prev_sign);
      end else begin
        check("bcd_result", bcd_result, eb);
        check("bcd_remainder", bcd_remainder, er);
        check("seg_result", seg_result, es);
        check("sign_out", sign_out, s);
      end
    end
    ready = 1'b0;
    @(negedge clk);
    prev_bcd = eb; prev_rem = er; prev_seg = es; prev_sign = s;
  endtask

  initial begin
    int n_done;
    int unsigned rv, rmv;
    bit sv;

    tbl[0] = '{12345, 3,     1'b0, 20'h12345, 20'h00003};
    tbl[1] = '{0,     0,     1'b0, 20'h00000, 20'h00000};
    tbl[2] = '{65535, 65535, 1'b0, 20'h65535, 20'h65535};
    tbl[3] = '{7,     3,     1'b0, 20'h00007, 20'h00003};
    tbl[4] = '{42,    10,    1'b1, 20'h00042, 20'h00010};
    tbl[5] = '{1000,  999,   1'b0, 20'h01000, 20'h00999};
    tbl[6] = '{9,     0,     1'b1, 20'h00009, 20'h00000};

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bcd", bcd_result, '0);
    check("rst_rem", bcd_remainder, '0);
    check("rst_seg", seg_result, SEG_RST);
    check("rst_sign", sign_out, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Table vectors: hand-written constants against the DUT
    for (int i = 0; i < 7; i++) begin
      start(tbl[i].res, tbl[i].rem, tbl[i].sg);
      watch(tbl[i].res, tbl[i].rem, tbl[i].sg, 0);
      check("tbl_bcd", bcd_result, tbl[i].eb);
`ifdef MDR_BCD_REMAINDER_EN
      check("tbl_rem", bcd_remainder, tbl[i].er);
`endif
    end

    // Random values against the reference model
    for (int i = 0; i < 20; i++) begin
      rv  = $urandom_range(0, 65535);
      rmv = $urandom_range(0, 65535);
      sv  = 1'($urandom_range(0, 1));
      start(rv, rmv, sv);
      watch(rv, rmv, sv, 0);
    end

    // Second ready edge mid-conversion must be ignored
    start(321, 12, 1'b1);
    watch(321, 12, 1'b1, 5);

    // Reset mid-conversion aborts without a done
    start(999, 5, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) ready = 1'b0;
    end
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_bcd", bcd_result, '0);
    check("abort_rem", bcd_remainder, '0);
    check("abort_seg", seg_result, SEG_RST);
    check("abort_sign", sign_out, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    n_done = 0;
    for (int k = 0; k < 2*LAT + 4; k++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("abort_no_done", n_done, 0);
    prev_bcd = '0; prev_rem = '0; prev_seg = SEG_RST; prev_sign = 1'b0;

    // Ready already high when reset releases counts as an edge
    @(negedge clk);
    reset = 1'b0;
    result = 16'd500; remainder = 16'd77; sign = 1'b0; ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    watch(500, 77, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
